// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the hazard stall controller
//
// Purpose : FSM state type, zero-register index, A64 opcode constants for the
//           instructions the hazard logic cares about, and a register-match helper.
// Ports   : none (package).
// Config  : HAZARD_PERF_EN is consumed by hazard_stall_controller, not here.
package cpu_pkg;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } hz_state_t;

    localparam logic [4:0]  REG_ZR    = 5'd31;

    // Primary opcode fields as decoded in ID.
    localparam logic [10:0] OP_LDUR   = 11'h7C2;
    localparam logic [10:0] OP_STUR   = 11'h7C0;
    localparam logic [7:0]  OP_CBZ    = 8'hB4;
    localparam logic [10:0] OP_BR     = 11'h6B0;

    // A producer/consumer pair conflicts only when the comparison is active and
    // the register is not XZR, which reads as zero and is never written.
    function automatic logic reg_hit(input logic [4:0] src,
                                     input logic [4:0] dst,
                                     input logic       active);
        return active && (src == dst) && (src != REG_ZR);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-hazard comparators
//
// Purpose : Flags the three hazards forwarding cannot cover.
// Ports   : id_*            - ID-stage instruction fields and use flags
//           ex_mem_read_i/ex_rd_i   - EX holds an LDUR and its destination
//           mem_mem_read_i/mem_rd_i - MEM holds an LDUR and its destination
//           lu_hit_o  - ALU/STUR in ID reads the load in EX
//           cbz_ex_o  - CBZ/BR in ID reads the load in EX
//           cbz_mem_o - CBZ/BR in ID reads the load in MEM
module hazard_detect
    import cpu_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [4:0] id_rn_i,
    input  logic [4:0] id_rm_i,
    input  logic [4:0] id_rd_i,
    input  logic       id_uses_rn_i,
    input  logic       id_uses_rm_i,
    input  logic       cbz_or_br_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       mem_mem_read_i,
    input  logic [4:0] mem_rd_i,
    output logic       lu_hit_o,
    output logic       cbz_ex_o,
    output logic       cbz_mem_o
);

    logic rn_active;
    logic rm_active;
    logic rd_active;

    assign rn_active = id_valid_i && id_uses_rn_i;
    assign rm_active = id_valid_i && id_uses_rm_i;
    // CBZ tests Rd and BR jumps through Rd, so both read it in ID.
    assign rd_active = id_valid_i && cbz_or_br_i;

    assign lu_hit_o  = ex_mem_read_i &&
                       (reg_hit(id_rn_i, ex_rd_i, rn_active) ||
                        reg_hit(id_rm_i, ex_rd_i, rm_active));
    assign cbz_ex_o  = ex_mem_read_i  && reg_hit(id_rd_i, ex_rd_i,  rd_active);
    assign cbz_mem_o = mem_mem_read_i && reg_hit(id_rd_i, mem_rd_i, rd_active);

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-hazard stall sequencer and branch flush control
//
// Purpose : Stalls PC and IF/ID and bubbles ID/EX for N cycles on a load hazard,
//           and flushes IF/ID when an ID branch resolves taken.
// Ports   : clk, rst (sync, active high); ID/EX/MEM hazard inputs;
//           pc_write, if_id_write, id_ex_bubble, if_id_flush pipeline controls;
//           stall_cycles, flush_count performance counters.
// Config  : HAZARD_PERF_EN - when defined, stall_cycles/flush_count are saturating
//           counters; otherwise both ports read 0 and no counter flops exist.
module hazard_stall_controller
    import cpu_pkg::*;
#(
    parameter int LU_BUBBLES  = 1,
    parameter int CBZ_BUBBLES = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_Rn,
    input  logic [4:0]  id_Rm,
    input  logic [4:0]  id_Rd,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm,
    input  logic        cbz_or_br,
    input  logic        br_taken,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_Rd,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_Rd,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    if (LU_BUBBLES < 1 || LU_BUBBLES > 3) begin : g_bad_lu
        $error("hazard_stall_controller: LU_BUBBLES must be 1..3");
    end
    if (CBZ_BUBBLES < 1 || CBZ_BUBBLES > 3) begin : g_bad_cbz
        $error("hazard_stall_controller: CBZ_BUBBLES must be 1..3");
    end

    localparam logic [1:0] LU_N      = 2'(LU_BUBBLES);
    localparam logic [1:0] CBZ_EX_N  = 2'(CBZ_BUBBLES);
    localparam logic [1:0] CBZ_MEM_N = 2'(CBZ_BUBBLES - 1);

    logic      lu_hit;
    logic      cbz_ex;
    logic      cbz_mem;
    logic [1:0] need_n;
    logic      stall;
    logic      flush;

    hz_state_t  state_q;
    logic [1:0] cnt_q;

    hazard_detect u_detect (
        .id_valid_i     (id_valid),
        .id_rn_i        (id_Rn),
        .id_rm_i        (id_Rm),
        .id_rd_i        (id_Rd),
        .id_uses_rn_i   (id_uses_rn),
        .id_uses_rm_i   (id_uses_rm),
        .cbz_or_br_i    (cbz_or_br),
        .ex_mem_read_i  (ex_mem_read),
        .ex_rd_i        (ex_Rd),
        .mem_mem_read_i (mem_mem_read),
        .mem_rd_i       (mem_Rd),
        .lu_hit_o       (lu_hit),
        .cbz_ex_o       (cbz_ex),
        .cbz_mem_o      (cbz_mem)
    );

    // Largest bubble requirement among the hazards present this cycle.
    always_comb begin
        need_n = 2'd0;
        if (lu_hit && (LU_N > need_n)) begin
            need_n = LU_N;
        end
        if (cbz_ex && (CBZ_EX_N > need_n)) begin
            need_n = CBZ_EX_N;
        end
        if (cbz_mem && (CBZ_MEM_N > need_n)) begin
            need_n = CBZ_MEM_N;
        end
    end

    // The first stall cycle comes straight from detection; S_STALL covers the rest.
    assign stall = (state_q == S_STALL) || (need_n != 2'd0);
    // A stalled branch has stale operands, so it must not flush; it resolves again later.
    assign flush = br_taken && id_valid && !stall;

    // During reset every control is forced high so the pipeline clears to NOPs.
    assign pc_write     = rst || !stall;
    assign if_id_write  = rst || !stall;
    assign id_ex_bubble = rst || stall;
    assign if_id_flush  = rst || flush;

    // cnt_q holds the stall cycles still owed after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (need_n > 2'd1) begin
                        state_q <= S_STALL;
                        cnt_q   <= need_n - 2'd1;
                    end
                end
                S_STALL: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= 2'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule
